// File: rtl/uart_ascii_pkg.sv
// ---------------------------------------------------------------------------
// uart_ascii_pkg
// Shared definitions for the RX-side ASCII parsers: the character codes the
// parsers recognise and the parser state encoding.
// ---------------------------------------------------------------------------
package uart_ascii_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for the first byte of a field
    ACCUM = 2'd1,  // collecting digits
    SKIP  = 2'd2,  // bad field: discard up to the next terminator
    DONE  = 2'd3   // number presented, waiting for the consumer
  } state_e;

endpackage

// File: rtl/uart_ascii2num_if.sv
// ---------------------------------------------------------------------------
// uart_ascii2num_if
// Groups the byte input stream, the number output stream and the error pulses
// of the decimal parser.
//   slave  : the parser side (consumes rx_*, produces num_* and err_*)
//   master : the environment side (RX buffer + number consumer)
// ---------------------------------------------------------------------------
interface uart_ascii2num_if #(
  parameter int WIDTH = 16
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [WIDTH-1:0] num;
  logic             num_valid;
  logic             num_ready;
  logic             err_char;
  logic             err_overflow;

  modport slave (
    input  rx_data, rx_valid, num_ready,
    output rx_ready, num, num_valid, err_char, err_overflow
  );

  modport master (
    output rx_data, rx_valid, num_ready,
    input  rx_ready, num, num_valid, err_char, err_overflow
  );
endinterface

// File: rtl/uart_char_class.sv
// ---------------------------------------------------------------------------
// uart_char_class
// Combinational classifier for one received ASCII byte.
//   rx_data  : byte to classify
//   is_digit : byte is '0'..'9'
//   is_term  : byte is CR or LF
//   is_minus : byte is '-'
//   digit    : numeric value of the byte (meaningful only when is_digit)
// ---------------------------------------------------------------------------
module uart_char_class
  import uart_ascii_pkg::*;
(
  input  logic [7:0] rx_data,
  output logic       is_digit,
  output logic       is_term,
  output logic       is_minus,
  output logic [3:0] digit
);

  always_comb begin
    is_digit = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
    is_term  = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
    is_minus = (rx_data == ASCII_MINUS);
    digit    = 4'(rx_data - ASCII_0);
  end

endmodule

// File: rtl/uart_ascii2num.sv
// ---------------------------------------------------------------------------
// uart_ascii2num
// Receive-side decimal parser. Accumulates '0'..'9' bytes into a binary
// number and presents it when a CR or LF terminator arrives. Empty fields
// (e.g. the LF of a CRLF pair) are ignored. Bad characters and out-of-range
// fields raise a one-cycle error pulse and the rest of the field is skipped.
//
// Ports:
//   clk     : system clock
//   reset_n : asynchronous reset, active low
//   bus     : uart_ascii2num_if.slave
//             rx_data/rx_valid/rx_ready   byte stream in
//             num/num_valid/num_ready     parsed number out
//             err_char/err_overflow       one-cycle error pulses
//
// Parameters:
//   WIDTH      : output number width
//   MAX_DIGITS : longest accepted digit string per field
//
// Build option UART_ASCII2NUM_NEG_EN: accept a leading '-' and present a
// two's-complement result with the signed range. Without it '-' is illegal
// and the result is unsigned.
// ---------------------------------------------------------------------------
module uart_ascii2num
  import uart_ascii_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_ascii2num_if.slave   bus
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int EXT_W = WIDTH + 4;  // holds acc*10+9 without wrapping

  localparam logic [EXT_W-1:0] EXT_ONE = EXT_W'(1);

`ifdef UART_ASCII2NUM_NEG_EN
  localparam bit NEG_EN = 1'b1;
`else
  localparam bit NEG_EN = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Character classification
  // -------------------------------------------------------------------------
  logic       is_digit;
  logic       is_term;
  logic       is_minus;
  logic [3:0] digit;

  uart_char_class u_char_class (
    .rx_data  (bus.rx_data),
    .is_digit (is_digit),
    .is_term  (is_term),
    .is_minus (is_minus),
    .digit    (digit)
  );

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic             err_char_q, err_char_d;
  logic             err_ovf_q, err_ovf_d;

  logic             accept;
  logic [EXT_W-1:0] acc_ext;
  logic [EXT_W-1:0] prod;
  logic [EXT_W-1:0] limit;

  // Never accept while a number is waiting for the consumer.
  assign bus.rx_ready = (state_q != DONE);
  assign accept       = bus.rx_valid && bus.rx_ready;

  // acc*10 + d, built from shifts so no multiplier is needed.
  always_comb begin
    acc_ext = {4'b0000, acc_q};
    prod    = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, digit};
  end

  // Largest magnitude the current field may reach.
  always_comb begin
`ifdef UART_ASCII2NUM_NEG_EN
    limit = neg_q ? (EXT_ONE << (WIDTH - 1)) : ((EXT_ONE << (WIDTH - 1)) - EXT_ONE);
`else
    limit = {4'b0000, {WIDTH{1'b1}}};
`endif
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    num_d      = num_q;
    err_char_d = 1'b0;
    err_ovf_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_digit) begin
            state_d = ACCUM;
            acc_d   = WIDTH'(digit);
            cnt_d   = CNT_W'(1);
            neg_d   = 1'b0;
          end else if (NEG_EN && is_minus) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            neg_d   = 1'b1;
          end else if (!is_term) begin
            // A terminator here is an empty field and is simply dropped.
            state_d    = SKIP;
            err_char_d = 1'b1;
          end
        end
      end

      ACCUM: begin
        if (accept) begin
          if (is_digit) begin
            if ((cnt_q == CNT_W'(MAX_DIGITS)) || (prod > limit)) begin
              state_d   = SKIP;
              err_ovf_d = 1'b1;
            end else begin
              acc_d = prod[WIDTH-1:0];
              cnt_d = cnt_q + 1'b1;
            end
          end else if (is_term) begin
            if (cnt_q == '0) begin
              // Only a '-' was seen; the terminator already ends the field.
              state_d    = IDLE;
              acc_d      = '0;
              neg_d      = 1'b0;
              err_char_d = 1'b1;
            end else begin
              state_d = DONE;
              num_d   = neg_q ? ('0 - acc_q) : acc_q;
            end
          end else begin
            state_d    = SKIP;
            err_char_d = 1'b1;
          end
        end
      end

      SKIP: begin
        if (accept && is_term) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          neg_d   = 1'b0;
        end
      end

      DONE: begin
        if (bus.num_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          neg_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      num_q      <= '0;
      err_char_q <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      num_q      <= num_d;
      err_char_q <= err_char_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  assign bus.num          = num_q;
  assign bus.num_valid    = (state_q == DONE);
  assign bus.err_char     = err_char_q;
  assign bus.err_overflow = err_ovf_q;

endmodule

// File: tb/tb_uart_ascii2num.sv
// ---------------------------------------------------------------------------
// tb_uart_ascii2num
// Directed stimulus for uart_ascii2num. Each field sent pushes its expected
// outcome (a number or an error pulse) into a queue; an independent monitor
// pops and compares whenever the DUT completes a number handshake or pulses
// an error.
// ---------------------------------------------------------------------------
module tb_uart_ascii2num;
  import uart_ascii_pkg::*;

  localparam int WIDTH = 16;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  typedef enum logic [1:0] {EV_NUM, EV_ECHAR, EV_EOVF} ev_kind_e;
  typedef struct {
    ev_kind_e         kind;
    logic [WIDTH-1:0] value;
  } ev_t;

  ev_t exp_q[$];

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_ascii2num_if #(.WIDTH(WIDTH)) bus ();

  uart_ascii2num #(.WIDTH(WIDTH), .MAX_DIGITS(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // ---------------- scoreboard ----------------
  task automatic expect_num(input logic [WIDTH-1:0] v);
    ev_t e;
    e.kind  = EV_NUM;
    e.value = v;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input ev_kind_e k);
    ev_t e;
    e.kind  = k;
    e.value = '0;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input ev_kind_e k, input logic [WIDTH-1:0] v, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: unexpected event, value %0h, nothing expected", name, v);
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, 32'(k), 32'(e.kind));
      if (e.kind == EV_NUM && k == EV_NUM) check({name, "_value"}, 32'(v), 32'(e.value));
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.err_char)                   pop_check(EV_ECHAR, '0, "err_char");
      if (bus.err_overflow)               pop_check(EV_EOVF, '0, "err_overflow");
      if (bus.num_valid && bus.num_ready) pop_check(EV_NUM, bus.num, "num");
    end
  end

  // ---------------- drivers ----------------
  // Called at posedge+1; returns at posedge+1 after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    bit seen;
    seen         = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = bus.rx_ready;
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0;
    if (!seen) begin
      n_total++;
      $display("FAIL send_timeout: byte %0h not accepted within 50 cycles", b);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_num"},       32'(bus.num), 32'h0);
    check({tag, "_num_valid"}, 32'(bus.num_valid), 32'h0);
    check({tag, "_rx_ready"},  32'(bus.rx_ready), 32'h1);
    check({tag, "_err_char"},  32'(bus.err_char), 32'h0);
    check({tag, "_err_ovf"},   32'(bus.err_overflow), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.num_ready = 1'b1;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // 1: plain number
    expect_num(16'd123);
    send_str("123"); send_byte(CR);

    // 2: full-range value, CRLF yields a single number
    expect_num(16'hFFFF);
    send_str("65535"); send_byte(CR); send_byte(LF);

    // 3: value overflow, then recovery
    expect_err(EV_EOVF);
    send_str("65536"); send_byte(CR);
    expect_num(16'd7);
    send_str("7"); send_byte(CR);

    // 4: illegal character, rest of field skipped, then recovery
    expect_err(EV_ECHAR);
    send_str("1a2"); send_byte(CR);
    expect_num(16'd42);
    send_str("42"); send_byte(LF);

    // Digit-count overflow even though the value fits; zero and empty field
    expect_err(EV_EOVF);
    send_str("000001"); send_byte(CR);
    expect_num(16'd0);
    send_str("0"); send_byte(CR);
    send_byte(CR);

    // 5: back-pressure with the next byte already pending
    expect_num(16'd9);
    expect_num(16'd8);
    bus.num_ready = 1'b0;
    send_str("9"); send_byte(CR);
    bus.rx_data  = "8";
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rx_ready",  32'(bus.rx_ready), 32'h0);
      check("stall_num_valid", 32'(bus.num_valid), 32'h1);
      check("stall_num",       32'(bus.num), 32'd9);
      @(posedge clk);
      #1;
    end
    bus.num_ready = 1'b1;
    @(negedge clk);
    check("hs_rx_ready", 32'(bus.rx_ready), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_hs_rx_ready", 32'(bus.rx_ready), 32'h1);
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
    send_byte(CR);

    // 6: reset in the middle of a field discards it
    send_str("12");
    reset_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs("mid_reset");
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    expect_num(16'd3);
    send_str("3"); send_byte(CR);

`ifdef UART_ASCII2NUM_NEG_EN
    expect_num(16'hFFFB);
    send_str("-5"); send_byte(CR);
    expect_num(16'h8000);
    send_str("-32768"); send_byte(CR);
    expect_err(EV_EOVF);
    send_str("32768"); send_byte(CR);
    expect_num(16'h7FFF);
    send_str("32767"); send_byte(CR);
    expect_err(EV_EOVF);
    send_str("-32769"); send_byte(CR);
    expect_err(EV_ECHAR);
    send_str("-"); send_byte(CR);
    expect_err(EV_ECHAR);
    send_str("5-"); send_byte(CR);
    expect_num(16'd11);
    send_str("11"); send_byte(CR);
`else
    expect_err(EV_ECHAR);
    send_str("-5"); send_byte(CR);
    expect_num(16'd5);
    send_str("5"); send_byte(CR);
`endif

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
